// File: rtl/risc_pkg.sv
// risc_pkg: shared widths, D-mux select encodings and register index constants
package risc_pkg;
   localparam int RISC_DATA_W = 8;
   localparam int RISC_ADDR_W = 3;
   localparam int R0 = 0;
   typedef enum logic [1:0] {
      MD_F   = 2'b00,
      MD_MEM = 2'b01,
      MD_Y   = 2'b10
   } md_e;
endpackage

// File: rtl/reg_array.sv
// reg_array: 2**ADDR_W x DATA_W storage, one sync write port, two async read ports
//   clk, rst_n         clock, async active-low clear of all entries
//   we_i/waddr_i/wdata_i  write port, committed on rising edge
//   raddr_a_i/rdata_a_o   read port A (combinational)
//   raddr_b_i/rdata_b_o   read port B (combinational)
module reg_array
   import risc_pkg::*;
#(
   parameter int DATA_W = RISC_DATA_W,
   parameter int ADDR_W = RISC_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_a_i,
   input  logic [ADDR_W-1:0] raddr_b_i,
   output logic [DATA_W-1:0] rdata_a_o,
   output logic [DATA_W-1:0] rdata_b_o
);
   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) mem_q <= '{default: '0};
      else if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_a_o = mem_q[raddr_a_i];
   assign rdata_b_o = mem_q[raddr_b_i];
endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: write-back register plus register file with bypassed read ports
//   clk, rst_n       clock, async active-low reset
//   RW, DA, D_in     write request captured into the write-back register
//   AA/A_data        read port A, BA/B_data read port B (combinational)
//   wb_pending       write-back register holds an uncommitted write
//   wb_addr          destination of that pending write
module reg_file_wb
   import risc_pkg::*;
#(
   parameter int DATA_W  = RISC_DATA_W,
   parameter int ADDR_W  = RISC_ADDR_W,
   parameter bit ZERO_R0 = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              RW,
   input  logic [ADDR_W-1:0] DA,
   input  logic [DATA_W-1:0] D_in,
   input  logic [ADDR_W-1:0] AA,
   input  logic [ADDR_W-1:0] BA,
   output logic [DATA_W-1:0] A_data,
   output logic [DATA_W-1:0] B_data,
   output logic              wb_pending,
   output logic [ADDR_W-1:0] wb_addr
);
   localparam logic [ADDR_W-1:0] R0_A = ADDR_W'(R0);
   logic              wb_valid_q, wb_valid_d;
   logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [DATA_W-1:0] arr_a, arr_b;
   // Writes to a hard-wired R0 are dropped at capture so they never commit or bypass.
   always_comb begin
      wb_valid_d = RW && !(ZERO_R0 && DA == R0_A);
      wb_addr_d  = wb_valid_d ? DA : wb_addr_q;
      wb_data_d  = wb_valid_d ? D_in : wb_data_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wb_valid_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
      end else begin
         wb_valid_q <= wb_valid_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
      end
   reg_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_arr (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (wb_valid_q),
      .waddr_i   (wb_addr_q),
      .wdata_i   (wb_data_q),
      .raddr_a_i (AA),
      .raddr_b_i (BA),
      .rdata_a_o (arr_a),
      .rdata_b_o (arr_b)
   );
   // Bypass from the write-back register only; D_in is never forwarded combinationally.
   assign A_data = (ZERO_R0 && AA == R0_A) ? '0 : (wb_valid_q && wb_addr_q == AA) ? wb_data_q : arr_a;
   assign B_data = (ZERO_R0 && BA == R0_A) ? '0 : (wb_valid_q && wb_addr_q == BA) ? wb_data_q : arr_b;
   assign wb_pending = wb_valid_q;
   assign wb_addr    = wb_addr_q;
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed self-checking bench for reg_file_wb
module tb_reg_file_wb;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       RW;
   logic [2:0] DA, AA, BA;
   logic [7:0] D_in, A_data, B_data;
   logic       wb_pending;
   logic [2:0] wb_addr;
   int checks = 0;
   int errors = 0;

   reg_file_wb #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(1'b1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .RW         (RW),
      .DA         (DA),
      .D_in       (D_in),
      .AA         (AA),
      .BA         (BA),
      .A_data     (A_data),
      .B_data     (B_data),
      .wb_pending (wb_pending),
      .wb_addr    (wb_addr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      RW = 1'b1; DA = 3'd3; D_in = 8'h5A; AA = 3'd3; BA = 3'd3;
      tick();
      RW = 1'b0;
      tick();
      #1;
      checks++;
      if (A_data !== 8'h5A) begin errors++; $display("FAIL reset_preload: A_data=%h expected 5a", A_data); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (A_data !== 8'h00 || B_data !== 8'h00) begin errors++; $display("FAIL reset_async_read: A=%h B=%h expected 00 00", A_data, B_data); end
      checks++;
      if (wb_pending !== 1'b0 || wb_addr !== 3'd0) begin errors++; $display("FAIL reset_wb: pending=%b addr=%0d expected 0 0", wb_pending, wb_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         AA = 3'(i); BA = 3'(7 - i);
         #1;
         checks++;
         if (A_data !== 8'h00 || B_data !== 8'h00) begin errors++; $display("FAIL reset_clear R%0d/R%0d: A=%h B=%h expected 00 00", i, 7 - i, A_data, B_data); end
      end
   endtask

   task automatic test_single_write();
      RW = 1'b1; DA = 3'd3; D_in = 8'hA5; AA = 3'd3; BA = 3'd0;
      #1;
      checks++;
      if (A_data !== 8'h00) begin errors++; $display("FAIL single_no_comb_bypass: A_data=%h expected 00", A_data); end
      tick();
      RW = 1'b0; D_in = 8'h00;
      #1;
      checks++;
      if (A_data !== 8'hA5 || wb_pending !== 1'b1 || wb_addr !== 3'd3) begin errors++; $display("FAIL single_bypass: A=%h pending=%b addr=%0d expected a5 1 3", A_data, wb_pending, wb_addr); end
      tick();
      checks++;
      if (A_data !== 8'hA5 || wb_pending !== 1'b0) begin errors++; $display("FAIL single_commit: A=%h pending=%b expected a5 0", A_data, wb_pending); end
   endtask

   task automatic test_back_to_back();
      RW = 1'b1; DA = 3'd2; D_in = 8'h11; AA = 3'd2; BA = 3'd3;
      tick();
      D_in = 8'h22;
      #1;
      checks++;
      if (A_data !== 8'h11 || wb_addr !== 3'd2) begin errors++; $display("FAIL b2b_first: A=%h addr=%0d expected 11 2", A_data, wb_addr); end
      tick();
      RW = 1'b0;
      #1;
      checks++;
      if (A_data !== 8'h22 || wb_pending !== 1'b1) begin errors++; $display("FAIL b2b_second: A=%h pending=%b expected 22 1", A_data, wb_pending); end
      checks++;
      if (B_data !== 8'hA5) begin errors++; $display("FAIL b2b_other_reg: B=%h expected a5", B_data); end
      tick();
      tick();
      checks++;
      if (A_data !== 8'h22 || wb_pending !== 1'b0) begin errors++; $display("FAIL b2b_drain: A=%h pending=%b expected 22 0", A_data, wb_pending); end
   endtask

   task automatic test_r0();
      RW = 1'b1; DA = 3'd0; D_in = 8'hFF; AA = 3'd0; BA = 3'd0;
      tick();
      RW = 1'b0;
      #1;
      checks++;
      if (wb_pending !== 1'b0) begin errors++; $display("FAIL r0_no_pending: pending=%b expected 0", wb_pending); end
      checks++;
      if (A_data !== 8'h00 || B_data !== 8'h00) begin errors++; $display("FAIL r0_read_bypass: A=%h B=%h expected 00 00", A_data, B_data); end
      tick();
      checks++;
      if (A_data !== 8'h00 || B_data !== 8'h00) begin errors++; $display("FAIL r0_read_array: A=%h B=%h expected 00 00", A_data, B_data); end
   endtask

   task automatic test_dual_port();
      RW = 1'b1; DA = 3'd1; D_in = 8'h10; AA = 3'd2; BA = 3'd3;
      tick();
      DA = 3'd4; D_in = 8'h7E;
      tick();
      RW = 1'b0; AA = 3'd4; BA = 3'd1;
      #1;
      checks++;
      if (A_data !== 8'h7E || B_data !== 8'h10) begin errors++; $display("FAIL dual_bypass_array: A=%h B=%h expected 7e 10", A_data, B_data); end
      checks++;
      if (wb_pending !== 1'b1 || wb_addr !== 3'd4) begin errors++; $display("FAIL dual_wb: pending=%b addr=%0d expected 1 4", wb_pending, wb_addr); end
      BA = 3'd4;
      #1;
      checks++;
      if (A_data !== 8'h7E || B_data !== 8'h7E) begin errors++; $display("FAIL dual_same_addr_bypass: A=%h B=%h expected 7e 7e", A_data, B_data); end
      tick();
      checks++;
      if (A_data !== 8'h7E || B_data !== 8'h7E) begin errors++; $display("FAIL dual_same_addr_array: A=%h B=%h expected 7e 7e", A_data, B_data); end
   endtask

   task automatic test_reset_mid_write();
      RW = 1'b1; DA = 3'd5; D_in = 8'h33; AA = 3'd5; BA = 3'd4;
      tick();
      RW = 1'b0;
      #1;
      checks++;
      if (A_data !== 8'h33 || wb_pending !== 1'b1 || wb_addr !== 3'd5) begin errors++; $display("FAIL midrst_captured: A=%h pending=%b addr=%0d expected 33 1 5", A_data, wb_pending, wb_addr); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (A_data !== 8'h00 || B_data !== 8'h00 || wb_pending !== 1'b0) begin errors++; $display("FAIL midrst_async: A=%h B=%h pending=%b expected 00 00 0", A_data, B_data, wb_pending); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (A_data !== 8'h00 || wb_pending !== 1'b0 || wb_addr !== 3'd0) begin errors++; $display("FAIL midrst_dropped: A=%h pending=%b addr=%0d expected 00 0 0", A_data, wb_pending, wb_addr); end
   endtask

   initial begin
      rst_n = 1'b0; RW = 1'b0; DA = '0; D_in = '0; AA = '0; BA = '0;
      #12;
      rst_n = 1'b1;
      test_reset();
      test_single_write();
      test_back_to_back();
      test_r0();
      test_dual_port();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
